pwm_decoder: RTL and testbench
==============================

Name: pwm_decoder

Overview:
- Receive-side counterpart of the PWM generator (clk, rstb, level, out).
- Recovers the level word from a 1-bit PWM or sigma-delta bitstream by counting high samples over a free-running window of 2^C_LEVEL_WIDTH clocks (sinc1 decimation).
- Sits between the bitstream source (PWM generator loopback or comparator output) and the downstream level consumer.
- Emits one level word per window, with a valid strobe and a stability flag.

Parameters:
- C_LEVEL_WIDTH, 8, width of the recovered level; window length N = 2^C_LEVEL_WIDTH clocks.
- C_STABLE_CNT, 2, number of consecutive identical windows required to assert stable (≥1).

Ports:
- clk  input  1  main clock; all logic on rising edge.
- rstb  input  1  asynchronous active-low reset.
- in  input  1  PWM/bitstream input; same clock domain unless PWM_DEC_SYNC_EN.
- level  output  C_LEVEL_WIDTH  recovered level of the last completed window.
- valid  output  1  one-cycle pulse when level updates.
- stable  output  1  high while the last C_STABLE_CNT windows gave the same level.

Behaviour:
- Reset (rstb=0, asynchronous): level=0, valid=0, stable=0, window counter=0, ones counter=0, match counter=0, state=WARMUP.
- Window counter: C_LEVEL_WIDTH bits, increments every clock, wraps N-1→0. Frame end is the cycle with counter==N-1.
- Ones counter: C_LEVEL_WIDTH+1 bits, adds the sampled input each clock.
  - On the frame-end cycle the total includes that cycle's sample.
  - The counter then restarts at 0, or at 1 if the first sample of the next window is high. No sample is lost or double-counted.
- Result width rule: total in 0..N; total==N saturates to N-1 (all ones). Otherwise level = total[C_LEVEL_WIDTH-1:0].
- State machine:
  - WARMUP: the first frame end after reset discards its total. No valid pulse, level stays 0, go to RUN. This covers synchronizer fill and the partial first window.
  - RUN: each frame end registers level on the next clock edge, with valid=1 for exactly that cycle. Stay in RUN.
  - Only reset returns the block to WARMUP.
- Latency: level/valid appear 1 clock after the frame-end sample, plus 2 clocks when PWM_DEC_SYNC_EN is defined. Valid period is exactly N clocks in RUN.
- Stability:
  - On each update, new level == previous level increments the match counter (saturating at C_STABLE_CNT-1); otherwise it clears.
  - stable = (match counter == C_STABLE_CNT-1), updated together with valid.
  - With C_STABLE_CNT=1, stable=1 on every update.
- Phase independence: for a constant PWM of period N and duty k (0≤k≤N-1), every RUN window yields exactly k, whatever the phase.
- Constant input: 0 gives level=0; 1 gives level=N-1 (saturated).
- Reset mid-window: all state clears immediately and the next level is produced after a full WARMUP window plus one RUN window.

Optional Feature:
- Macro PWM_DEC_SYNC_EN.
- Defined: in passes through a 2-flop synchronizer (reset to 0) before counting. Adds 2 cycles latency; valid cadence unchanged.
- Undefined: in is sampled directly and must already be synchronous to clk.

Decomposition:
- Package pwm_pkg holds:
  - default C_LEVEL_WIDTH constant;
  - decoder state typedef (WARMUP, RUN);
  - a function for saturating an (W+1)-bit count to W bits.
- Sub-module pwm_sync (2-flop synchronizer, async active-low reset), instantiated only under PWM_DEC_SYNC_EN. The core counters stay in pwm_decoder.

Test Plan:
- Reset then in=0 held, C_LEVEL_WIDTH=8 → no valid for the first 256 clocks; then valid every 256 clocks with level=0x00, stable=1 from the second update.
- in=1 held → level=0xFF (saturated from 256) on every update, never 0x00.
- PWM generator loopback at level 0x40, random phase offset 0..255 → every RUN update level=0x40; swept for levels 2^i-1, i=0..8 (0x00 … 0xFF).
- Level step 0x10→0x80 mid-window → one intermediate value between 0x10 and 0x80, stable drops to 0, then 0x80 with stable=1 after C_STABLE_CNT matching windows.
- rstb pulsed low mid-window → outputs 0 immediately, WARMUP repeated, first valid 512 clocks after release (514 with PWM_DEC_SYNC_EN).
- PWM_DEC_SYNC_EN on vs off, same stimulus → identical level sequence, valid shifted by exactly 2 clocks.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types, defaults and helpers for the PWM decoder slice.
package pwm_pkg;

    // Default recovered-level width; window length is 2**width clocks
    localparam int unsigned C_LEVEL_WIDTH_DEF = 8;

    // Widest level the saturation helper handles
    localparam int unsigned SAT_MAX_W = 31;

    // Decoder state: discard the first (partial) window, then run
    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } decState_t;

    // Clamp a (w+1)-bit ones count to w bits: a full window (2**w) maps to all ones
    function automatic logic [SAT_MAX_W-1:0] satLevel(
        input logic [SAT_MAX_W:0] total,
        input int unsigned        w
    );
        logic [SAT_MAX_W:0] lim;
        lim = (SAT_MAX_W+1)'(1) << w;
        if (total >= lim) begin
            return SAT_MAX_W'(lim - (SAT_MAX_W+1)'(1));
        end
        return SAT_MAX_W'(total);
    endfunction

endpackage

// File: rtl/pwm_sync.sv
// pwm_sync: two-flop synchronizer with asynchronous active-low reset to 0.
module pwm_sync (
    input  logic clk,
    input  logic rstb,
    input  logic in,
    output logic out
);

    logic meta;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            meta <= 1'b0;
            out  <= 1'b0;
        end else begin
            meta <= in;
            out  <= meta;
        end
    end

endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder: sinc1 decimator recovering a level word from a PWM/sigma-delta
// bitstream over a free-running window of 2**C_LEVEL_WIDTH clocks.
// Optional macro PWM_DEC_SYNC_EN: the input passes through a 2-flop
// synchronizer and the window timing is held off by the same 2 clocks, so the
// level sequence is unchanged and only shifted in time.
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int unsigned C_LEVEL_WIDTH = C_LEVEL_WIDTH_DEF,
    parameter int unsigned C_STABLE_CNT  = 2
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     in,
    output logic [C_LEVEL_WIDTH-1:0] level,
    output logic                     valid,
    output logic                     stable
);

    localparam int unsigned LW      = C_LEVEL_WIDTH;
    localparam int unsigned CW      = C_LEVEL_WIDTH + 1;
    localparam int unsigned MATCH_W = (C_STABLE_CNT > 1) ? $clog2(C_STABLE_CNT) : 1;
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(C_STABLE_CNT - 1);

    logic              sample;
    logic              armed;
    logic [LW-1:0]     winCnt;
    logic [CW-1:0]     onesCnt;
    logic [CW-1:0]     total;
    logic              frameEnd;
    decState_t         state;
    decState_t         nextState;
    logic              update;
    logic [LW-1:0]     newLevel;
    logic [MATCH_W-1:0] matchCnt;
    logic [MATCH_W-1:0] matchNext;
    logic              hasPrev;

`ifdef PWM_DEC_SYNC_EN
    // Synchronized input; the arm flag delays counting to line windows up with it
    pwm_sync u_inSync (
        .clk  (clk),
        .rstb (rstb),
        .in   (in),
        .out  (sample)
    );

    pwm_sync u_armSync (
        .clk  (clk),
        .rstb (rstb),
        .in   (1'b1),
        .out  (armed)
    );
`else
    assign sample = in;
    assign armed  = 1'b1;
`endif

    // Window total including this cycle's sample
    assign total    = onesCnt + CW'(sample);
    assign frameEnd = armed && (winCnt == {LW{1'b1}});
    assign newLevel = LW'(satLevel((SAT_MAX_W+1)'(total), LW));

    // Free-running window position
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            winCnt <= '0;
        end else if (armed) begin
            winCnt <= winCnt + LW'(1);
        end
    end

    // Ones accumulator; the frame-end sample lands in total, next window starts empty
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            onesCnt <= '0;
        end else if (armed) begin
            onesCnt <= frameEnd ? '0 : total;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= WARMUP;
        end else begin
            state <= nextState;
        end
    end

    // FSM next state: leave WARMUP at the first frame end, then stay in RUN
    always_comb begin
        nextState = state;
        if (state == WARMUP && frameEnd) begin
            nextState = RUN;
        end
    end

    // FSM outputs: publish a result only at frame ends while running
    always_comb begin
        update = 1'b0;
        if (state == RUN && frameEnd) begin
            update = 1'b1;
        end
    end

    // Match counter step: count repeats of the previous published level
    always_comb begin
        matchNext = '0;
        if (hasPrev && newLevel == level) begin
            matchNext = (matchCnt == MATCH_MAX) ? matchCnt : matchCnt + MATCH_W'(1);
        end
    end

    // Registered outputs and stability tracking
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            level    <= '0;
            valid    <= 1'b0;
            stable   <= 1'b0;
            matchCnt <= '0;
            hasPrev  <= 1'b0;
        end else begin
            valid <= update;
            if (update) begin
                level    <= newLevel;
                matchCnt <= matchNext;
                stable   <= (matchNext == MATCH_MAX);
                hasPrev  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: scoreboard bench for pwm_decoder (honours PWM_DEC_SYNC_EN).
module tb_pwm_decoder;

    localparam int unsigned W    = 8;
    localparam int unsigned N    = 1 << W;
    localparam int unsigned STAB = 2;
`ifdef PWM_DEC_SYNC_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 0;
`endif

    logic         clk  = 1'b0;
    logic         rstb = 1'b0;
    logic         in   = 1'b0;
    logic [W-1:0] level;
    logic         valid;
    logic         stable;

    pwm_decoder #(
        .C_LEVEL_WIDTH (W),
        .C_STABLE_CNT  (STAB)
    ) dut (
        .clk    (clk),
        .rstb   (rstb),
        .in     (in),
        .level  (level),
        .valid  (valid),
        .stable (stable)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned lvl;
        bit          stb;
        longint      stamp;
    } exp_t;

    exp_t        expQ[$];
    int          total = 0;
    int          bad   = 0;
    longint      edgeNo = 0;
    int unsigned phase  = 0;

    // Reference model state
    bit          inHist[$];
    int unsigned mPos  = 0;
    int unsigned mSum  = 0;
    bit          mWarm = 1'b1;
    int unsigned mHist[$];

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: sum each window of (delayed) samples, skip the first window
    always @(posedge clk or negedge rstb) begin
        bit          s;
        int unsigned lv;
        bit          st;
        if (!rstb) begin
            inHist.delete();
            mHist.delete();
            expQ.delete();
            mPos  = 0;
            mSum  = 0;
            mWarm = 1'b1;
        end else begin
            edgeNo++;
            inHist.push_back(in);
            if (inHist.size() > LAT) begin
                s = inHist.pop_front();
                mSum += int'(s);
                if (mPos == N - 1) begin
                    if (mWarm) begin
                        mWarm = 1'b0;
                    end else begin
                        lv = (mSum >= N) ? N - 1 : mSum;
                        mHist.push_back(lv);
                        st = (mHist.size() >= STAB);
                        for (int k = 0; k < STAB; k++) begin
                            if (mHist.size() >= STAB && mHist[mHist.size() - 1 - k] != lv) st = 1'b0;
                        end
                        expQ.push_back('{lv, st, edgeNo});
                    end
                    mSum = 0;
                    mPos = 0;
                end else begin
                    mPos++;
                end
            end
        end
    end

    // Monitor: every valid must match the next scoreboard entry in timing and value
    always @(negedge clk) begin
        bit   expV;
        exp_t e;
        if (rstb) begin
            expV = (expQ.size() > 0) && (expQ[0].stamp == edgeNo);
            if (valid || expV) checkVal("valid", 64'(valid), 64'(expV));
            if (expV) begin
                e = expQ.pop_front();
                if (valid) begin
                    checkVal("level", 64'(level), 64'(e.lvl));
                    checkVal("stable", 64'(stable), 64'(e.stb));
                end
            end
        end
    end

    // Drive a PWM of the given duty; duty == N means constant high
    task automatic drivePwm(input int unsigned duty, input int unsigned offs, input int unsigned cycles);
        for (int t = 0; t < cycles; t++) begin
            @(negedge clk);
            in = (((phase + offs) % N) < duty);
            phase++;
        end
    endtask

    initial begin
        int unsigned cnt;
        int unsigned lv;

        // Reset values
        repeat (3) @(negedge clk);
        checkVal("rst_level", 64'(level), 64'(0));
        checkVal("rst_valid", 64'(valid), 64'(0));
        checkVal("rst_stable", 64'(stable), 64'(0));
        #2 rstb = 1'b1;

        // Constant low, then constant high (saturated)
        drivePwm(0, 0, N * 4);
        checkVal("zero_level", 64'(level), 64'(0));
        checkVal("zero_stable", 64'(stable), 64'(1));
        drivePwm(N, 0, N * 4);
        checkVal("ones_level", 64'(level), 64'(N - 1));
        checkVal("ones_stable", 64'(stable), 64'(1));

        // Phase-independent recovery of 2**i-1 at random phases
        for (int i = 0; i <= 8; i++) begin
            lv = (1 << i) - 1;
            drivePwm(lv, $urandom_range(0, N - 1), N * 3);
            checkVal("sweep_level", 64'(level), 64'(lv));
            checkVal("sweep_stable", 64'(stable), 64'(1));
        end

        // Level step mid-window
        drivePwm(8'h10, 0, N * 3 + N / 2);
        drivePwm(8'h80, 0, N * 4);
        checkVal("step_level", 64'(level), 64'(8'h80));
        checkVal("step_stable", 64'(stable), 64'(1));

        // Reset mid-window: immediate clear, then WARMUP + one RUN window
        drivePwm(8'h40, 7, 100);
        @(negedge clk);
        #2 rstb = 1'b0;
        #1;
        checkVal("midrst_level", 64'(level), 64'(0));
        checkVal("midrst_valid", 64'(valid), 64'(0));
        checkVal("midrst_stable", 64'(stable), 64'(0));
        in = 1'b1;
        repeat (2) @(negedge clk);
        #2 rstb = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!valid && cnt < 1000);
        checkVal("midrst_latency", 64'(cnt), 64'(512 + LAT));
        checkVal("midrst_first", 64'(level), 64'(N - 1));

        // Random levels at random phases
        for (int j = 0; j < 4; j++) begin
            drivePwm($urandom_range(0, N - 1), $urandom_range(0, N - 1), N * 2 + $urandom_range(0, N - 1));
        end
        drivePwm(0, 0, N * 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
